keypad_spi_responder: RTL
=========================

# keypad_spi_responder

FPGA-side SPI slave that returns keypad events to the microcontroller over MISO. It sits beside the keypad scanner and the VGA SPI receiver. The scanner's single-cycle key pulses are queued in a small FIFO, and one event is shifted out per 8-bit SPI transaction that the MCU initiates. SPI inputs are asynchronous to `clk`; they are synchronized and edge-detected internally, so the whole block runs on one clock.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`: input, 1 bit. System clock. Every flop in the block uses it.
- `reset`: input, 1 bit. Asynchronous, active-high; clears all state.
- `key_valid`: input, 1 bit. One-`clk` pulse from the scanner indicating a new debounced key press.
- `key_code`: input, 4 bits. Key value; sampled only when `key_valid`=1.
- `sck`: input, 1 bit. SPI clock from the MCU, mode 0, asynchronous to `clk`.
- `cs_b`: input, 1 bit. SPI chip select, active-low, asynchronous.
- `miso`: output, 1 bit. Serial data to the MCU, MSB first.
- `fifo_count`: output, `$clog2(DEPTH)+1` bits. Number of queued events.
- `overflow`: output, 1 bit. Sticky flag: a push was dropped.

## Operation
- **Synchronizers:** `sck` and `cs_b` each pass through 2 flops, then an edge-detect flop. Call the results `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise` (one-`clk` pulses) and `cs_act` (synced `cs_b`=0).
- **Push:** when `key_valid`=1 and the FIFO is not full, write `key_code` and increment the write pointer.
  - When full with no pop in the same cycle, drop the event and set `overflow`.
- **Load:** on `cs_fall`, load `shreg[7:0]`:
  - FIFO non-empty: bit7=1, bits6:4=min(`fifo_count`−1, 7), bits3:0=head code.
  - FIFO empty: load 0x00.
  - Also clear `bitcnt` to 0.
- **Shifting:**
  - `miso` = `shreg[7]` while `cs_act`=1; `miso` = 0 otherwise.
  - On `sck_rise` with `cs_act`=1: `bitcnt`++.
  - On `sck_fall` with `cs_act`=1 and `bitcnt`<8: shift `shreg` left, filling with 0.
- **Pop:** when the 8th `sck_rise` of a transaction is seen (`bitcnt` going 7→8) and the loaded byte had bit7=1, advance the read pointer once.
  - Further edges in the same transaction do nothing; `miso` holds 0 after the byte.
- **Abort:** if `cs_rise` occurs before 8 rising edges, there is no pop. The same entry is sent again in the next transaction.
- **State machine:**
  - IDLE: wait for `cs_fall`; load, then go to SHIFT.
  - SHIFT: on the 8th rise, pop if valid, then go to DONE. On `cs_rise`, go to IDLE.
  - DONE: on `cs_rise`, go to IDLE.
  - A `cs_fall` in any state reloads and enters SHIFT.
- **Simultaneous push and pop:** both take effect and `fifo_count` is unchanged. A push while full is accepted if a pop happens in the same cycle.
- **Pointers:** wrap modulo `DEPTH`. `fifo_count` = write pointer − read pointer, using one extra pointer bit.

## Timing
- **Reset values:** `miso`=0, `fifo_count`=0, `overflow`=0, state=IDLE, pointers=0, `shreg`=0.
- **Push latency:** `fifo_count` updates 1 `clk` after the `key_valid` pulse.
- **Load latency:** pin `cs_b` falling → `miso` valid within 4 `clk`.
- **Shift latency:** pin `sck` falling → next bit on `miso` within 4 `clk`.
- **SCK limit:** `sck` frequency ≤ `clk`/8, and each `sck` phase ≥ 4 `clk`.
- **Pop timing:** 8th pin `sck` rise → `fifo_count` decrements within 4 `clk`.
- **Reset mid-transaction:** all state is cleared immediately and the in-flight byte is lost. If `cs_b` is still low when `reset` releases, nothing is sent until a new `cs_fall`.

## Configuration
- **Macro:** `KEYPAD_SPI_OVERFLOW_EN`.
- **Defined:**
  - Byte bit6 = `overflow`; bits5:4 = min(`fifo_count`−1, 3).
  - `overflow` clears after a completed transaction (8 rises) whose loaded byte carried bit6=1. A new set in that same cycle takes priority.
  - An empty FIFO with `overflow`=1 loads 0x40.
- **Undefined:**
  - Byte layout is as in Operation.
  - `overflow` stays sticky until `reset`, and is never serialized.

## Test plan
- Reset, then a transaction with the FIFO empty → `miso` bits 0x00; `fifo_count` stays 0.
- Push codes 0x5, 0xA, 0x3, then 3 full transactions → bytes 0xA5, 0x9A, 0x83; `fifo_count` goes 3→0.
- Push 0x7, then a transaction aborted after 4 edges, then a full transaction → 0x87 is sent both times; pop happens only after the second.
- Push `DEPTH`+2 events → `fifo_count`=`DEPTH`, `overflow`=1. With the macro defined, the first byte is 0xF0|code and `overflow` is 0 after that transaction.
- `key_valid` on the same `clk` as the pop with the FIFO full → `fifo_count` unchanged and the new code is at the tail.
- Assert `reset` mid-transaction (after bit 3), then release with `cs_b` low → `miso`=0 and no load until `cs_b` toggles high then low.

Source files
------------

// File: rtl/keypad_spi_responder_if.sv
// keypad_spi_responder_if
//   Groups the key-event push signals from the keypad scanner and the SPI
//   pins shared with the microcontroller.
//   master : drives key_valid/key_code (scanner side) and sck/cs_b (MCU side),
//            receives miso.
//   slave  : the responder; receives the above and drives miso.
interface keypad_spi_responder_if;
  logic       key_valid;  // one-clk pulse, new debounced key press
  logic [3:0] key_code;   // key value, valid with key_valid
  logic       sck;        // SPI clock, mode 0, asynchronous
  logic       cs_b;       // SPI chip select, active-low, asynchronous
  logic       miso;       // serial data to MCU, MSB first

  modport master (output key_valid, key_code, sck, cs_b, input miso);
  modport slave  (input key_valid, key_code, sck, cs_b, output miso);
endinterface

// File: rtl/keypad_spi_responder.sv
// keypad_spi_responder
//   SPI slave returning queued keypad events to the MCU. Key pulses are
//   pushed into a DEPTH-entry FIFO; each 8-bit SPI transaction (mode 0,
//   MSB first) shifts out one status byte and pops the head entry once
//   all 8 rising edges have been seen.
//   Byte layout: bit7 = entry valid, bits6:4 = min(count-1,7), bits3:0 = code.
//   Optional feature macro KEYPAD_SPI_OVERFLOW_EN: bit6 carries the overflow
//   flag, bits5:4 = min(count-1,3), and overflow clears once it has been
//   reported in a completed transaction.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high, clears all state
//   bus        : keypad_spi_responder_if.slave (key push + SPI pins)
//   fifo_count : number of queued events
//   overflow   : a push was dropped because the FIFO was full
module keypad_spi_responder #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  keypad_spi_responder_if.slave    bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // ---------------- synchronizers + edge detect ----------------
  logic sck_meta_reg, sck_sync_reg, sck_dly_reg;
  logic cs_meta_reg, cs_sync_reg, cs_dly_reg;

  // cs_b chain resets to 0 so that cs_b held low across reset release
  // does not look like a fresh falling edge; a genuine high-then-low
  // toggle is required before anything is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_meta_reg <= 1'b0;
      sck_sync_reg <= 1'b0;
      sck_dly_reg  <= 1'b0;
      cs_meta_reg  <= 1'b0;
      cs_sync_reg  <= 1'b0;
      cs_dly_reg   <= 1'b0;
    end else begin
      sck_meta_reg <= bus.sck;
      sck_sync_reg <= sck_meta_reg;
      sck_dly_reg  <= sck_sync_reg;
      cs_meta_reg  <= bus.cs_b;
      cs_sync_reg  <= cs_meta_reg;
      cs_dly_reg   <= cs_sync_reg;
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_act;
  assign sck_rise = sck_sync_reg & ~sck_dly_reg;
  assign sck_fall = ~sck_sync_reg & sck_dly_reg;
  assign cs_fall  = ~cs_sync_reg & cs_dly_reg;
  assign cs_rise  = cs_sync_reg & ~cs_dly_reg;
  assign cs_act   = ~cs_sync_reg;

  // ---------------- FIFO ----------------
  logic [3:0]  mem [DEPTH];
  logic [AW:0] wptr_reg, rptr_reg;
  logic        full, empty, push, pop, ovf_set;
  logic [3:0]  head;

  assign fifo_count = wptr_reg - rptr_reg;
  assign full       = (fifo_count == FULL_COUNT);
  assign empty      = (fifo_count == '0);
  // Head is read asynchronously: the load on cs_fall must see an entry
  // pushed in the immediately preceding cycle.
  assign head       = mem[rptr_reg[AW-1:0]];
  assign push       = bus.key_valid & (~full | pop);
  assign ovf_set    = bus.key_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg[AW-1:0]] <= bus.key_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + (AW+1)'(1);
      if (pop)  rptr_reg <= rptr_reg + (AW+1)'(1);
    end
  end

  // ---------------- byte assembly ----------------
  logic [AW+3:0] pending;
  logic [7:0]    load_byte;
  logic          overflow_reg;

  always_comb begin
    pending   = (AW+4)'(fifo_count) - (AW+4)'(1);
    load_byte = 8'h00;
`ifdef KEYPAD_SPI_OVERFLOW_EN
    load_byte[6] = overflow_reg;
    if (!empty) begin
      load_byte[7]   = 1'b1;
      load_byte[5:4] = (pending > (AW+4)'(3)) ? 2'd3 : pending[1:0];
      load_byte[3:0] = head;
    end
`else
    if (!empty) begin
      load_byte = {1'b1, (pending > (AW+4)'(7)) ? 3'd7 : pending[2:0], head};
    end
`endif
  end

  // ---------------- FSM ----------------
  state_t     state_reg, state_next;
  logic       load, done8;
  logic [7:0] shreg_reg;
  logic [3:0] bitcnt_reg;
  logic       loaded_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    done8      = 1'b0;
    if (cs_fall) begin
      load       = 1'b1;
      state_next = SHIFT;
    end else begin
      case (state_reg)
        SHIFT: begin
          if (cs_rise) begin
            state_next = IDLE;
          end else if (cs_act && sck_rise && bitcnt_reg == 4'd7) begin
            done8      = 1'b1;
            state_next = DONE;
          end
        end
        DONE:    if (cs_rise) state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  assign pop = done8 & loaded_valid_reg;

  // ---------------- shifter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_reg        <= 8'h00;
      bitcnt_reg       <= 4'd0;
      loaded_valid_reg <= 1'b0;
    end else if (load) begin
      shreg_reg        <= load_byte;
      bitcnt_reg       <= 4'd0;
      loaded_valid_reg <= load_byte[7];
    end else if (state_reg == SHIFT && cs_act) begin
      if (sck_rise) begin
        bitcnt_reg <= bitcnt_reg + 4'd1;
        // Clearing after the last rise keeps miso low for the rest of
        // the transaction.
        if (done8) shreg_reg <= 8'h00;
      end else if (sck_fall && bitcnt_reg < 4'd8) begin
        shreg_reg <= {shreg_reg[6:0], 1'b0};
      end
    end
  end

  assign bus.miso = shreg_reg[7] & cs_act;

  // ---------------- overflow flag ----------------
`ifdef KEYPAD_SPI_OVERFLOW_EN
  logic loaded_ovf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     loaded_ovf_reg <= 1'b0;
    else if (load) loaded_ovf_reg <= load_byte[6];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         overflow_reg <= 1'b0;
    else if (ovf_set)                  overflow_reg <= 1'b1;
    else if (done8 && loaded_ovf_reg)  overflow_reg <= 1'b0;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow_reg <= 1'b0;
    else if (ovf_set) overflow_reg <= 1'b1;
  end
`endif

  assign overflow = overflow_reg;

endmodule
